outwrctl: RTL and testbench

//  Sequences MVU quantizer output into local data memory for one job: accepts a 2-D write job,

---
 rtl/mvu_pkg.sv | 12 +
 rtl/outwrctl_addrgen.sv | 57 +++++
 rtl/outwrctl.sv | 112 +++++++++++
 tb/tb_outwrctl.sv | 183 ++++++++++++++++++
 4 files changed

// File: rtl/mvu_pkg.sv
// Shared MVU datapath defaults and the output write-controller state encoding.
package mvu_pkg;
    localparam int BDBANKA_DEF = 15;
    localparam int BDBANKW_DEF = 64;
    localparam int BCNT_DEF    = 10;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        FIN  = 2'd2
    } state_t;
endpackage

// File: rtl/outwrctl_addrgen.sv
// Strided 2-D write address generator: col/row counters with a running row base.
// Latency: addr/last are combinational from registered counters; load/step take effect next edge.
// Backpressure: none internally; the caller only pulses step on an accepted word.
module outwrctl_addrgen #(
    parameter int BDBANKA = 15,
    parameter int BCNT    = 10
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               load,
    input  logic               step,
    input  logic [BDBANKA-1:0] baseaddr,
    input  logic [BCNT-1:0]    len,
    input  logic [BCNT-1:0]    rows,
    input  logic [BDBANKA-1:0] stride,
    output logic [BDBANKA-1:0] addr,
    output logic               last
);
    logic [BCNT-1:0]    r_col;
    logic [BCNT-1:0]    r_row;
    logic [BCNT-1:0]    r_len;
    logic [BCNT-1:0]    r_rows;
    logic [BDBANKA-1:0] r_rowbase;
    logic [BDBANKA-1:0] r_stride;
    logic               w_row_end;

    assign w_row_end = (r_col == r_len - BCNT'(1));
    assign last      = w_row_end && (r_row == r_rows - BCNT'(1));
    // Address arithmetic wraps silently at the bank address width.
    assign addr      = r_rowbase + BDBANKA'(r_col);

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_col     <= '0;
            r_row     <= '0;
            r_len     <= '0;
            r_rows    <= '0;
            r_rowbase <= '0;
            r_stride  <= '0;
        end else if (load) begin
            r_col     <= '0;
            r_row     <= '0;
            r_len     <= len;
            r_rows    <= rows;
            r_rowbase <= baseaddr;
            r_stride  <= stride;
        end else if (step) begin
            if (w_row_end) begin
                r_col     <= '0;
                r_row     <= r_row + BCNT'(1);
                r_rowbase <= r_rowbase + r_stride;
            end else begin
                r_col     <= r_col + BCNT'(1);
            end
        end
    end
endmodule

// File: rtl/outwrctl.sv
// Writes one 2-D job of quantizer words into data memory at strided addresses.
// Latency: accept -> wreq 1 cycle; sustains 1 word/cycle with continuous grant.
// Backpressure: single-entry output stage; qready drops while a write waits for wgnt.
module outwrctl
    import mvu_pkg::*;
#(
    parameter int BDBANKA = BDBANKA_DEF,
    parameter int BDBANKW = BDBANKW_DEF,
    parameter int BCNT    = BCNT_DEF
) (
    input  logic               clk,
    input  logic               clr_n,
    input  logic               start,
    input  logic               abort,
    input  logic [BDBANKA-1:0] baseaddr,
    input  logic [BCNT-1:0]    len,
    input  logic [BCNT-1:0]    rows,
    input  logic [BDBANKA-1:0] stride,
    input  logic               qvalid,
    input  logic [BDBANKW-1:0] qdata,
    output logic               qready,
    output logic               wreq,
    output logic [BDBANKA-1:0] waddr,
    output logic [BDBANKW-1:0] wdata,
    input  logic               wgnt,
    output logic               busy,
    output logic               done
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic               w_load;
    logic               w_step;
    logic [BDBANKA-1:0] w_addr;
    logic               w_last;
    logic               r_wreq;
    logic [BDBANKA-1:0] r_waddr;
    logic [BDBANKW-1:0] r_wdata;
    logic               r_all_acc;

    outwrctl_addrgen #(
        .BDBANKA (BDBANKA),
        .BCNT    (BCNT)
    ) u_addrgen (
        .clk      (clk),
        .clr_n    (clr_n),
        .load     (w_load),
        .step     (w_step),
        .baseaddr (baseaddr),
        .len      (len),
        .rows     (rows),
        .stride   (stride),
        .addr     (w_addr),
        .last     (w_last)
    );

    assign qready = (r_state == RUN) && (!r_wreq || wgnt) && !r_all_acc;
    assign w_step = qvalid && qready && !abort;
    assign wreq   = r_wreq;
    assign waddr  = r_waddr;
    assign wdata  = r_wdata;
    assign busy   = (r_state != IDLE);
    assign done   = (r_state == FIN);

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        if (abort) begin
            w_state_nxt = IDLE;
        end else begin
            case (r_state)
                IDLE: if (start) begin
                    w_load      = 1'b1;
                    w_state_nxt = (len == '0 || rows == '0) ? FIN : RUN;
                end
                // all_accepted means the pending write is the job's final word.
                RUN:  if (r_wreq && wgnt && r_all_acc) w_state_nxt = FIN;
                FIN:  w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            r_wreq    <= 1'b0;
            r_waddr   <= '0;
            r_wdata   <= '0;
            r_all_acc <= 1'b0;
        end else if (abort) begin
            r_wreq    <= 1'b0;
            r_all_acc <= 1'b0;
        end else begin
            if (w_load) r_all_acc <= 1'b0;
            if (w_step) begin
                r_wreq  <= 1'b1;
                r_waddr <= w_addr;
                r_wdata <= qdata;
                if (w_last) r_all_acc <= 1'b1;
            end else if (wgnt) begin
                r_wreq  <= 1'b0;
            end
        end
    end
endmodule

// File: tb/tb_outwrctl.sv
// Randomized job bench for outwrctl: a job-level address/data model checks every granted write.
module tb_outwrctl;
    logic        clk = 1'b0;
    logic        clr_n;
    logic        start, abort, qvalid, wgnt;
    logic [14:0] baseaddr, stride;
    logic [9:0]  len, rows;
    logic [63:0] qdata;
    logic        qready, wreq, busy, done;
    logic [14:0] waddr;
    logic [63:0] wdata;

    int n_assert = 0;
    int n_fail   = 0;
    logic [78:0] exp_q[$];

    outwrctl dut (
        .clk(clk), .clr_n(clr_n), .start(start), .abort(abort),
        .baseaddr(baseaddr), .len(len), .rows(rows), .stride(stride),
        .qvalid(qvalid), .qdata(qdata), .qready(qready),
        .wreq(wreq), .waddr(waddr), .wdata(wdata), .wgnt(wgnt),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        n_assert++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    // Address of the k-th word of a job, straight from the row/column definition.
    function automatic logic [14:0] addr_of(input int base, input int l, input int st, input int k);
        int full;
        full = base + (k / l) * st + (k % l);
        return full[14:0];
    endfunction

    // kill_mode: 0 none, 1 abort, 2 reset, applied once kill_after writes have completed.
    // gmode: 0 grant always, 1 grant alternating, 2 grant random.
    task automatic run_job(input int base, input int l, input int r, input int st,
                           input int vprob, input int gmode, input int kill_mode,
                           input int kill_after, input bit mid_start, input bit full_rate);
        int total, acc, wr, cyc, first_acc, first_gnt, last_gnt;
        bit fin, prev_stall;
        logic [14:0] prev_a;
        logic [63:0] prev_d;
        logic [78:0] head;
        total = l * r; acc = 0; wr = 0; cyc = 0; fin = 0; prev_stall = 0;
        first_acc = -1; first_gnt = -1; last_gnt = -1; prev_a = '0; prev_d = '0;
        exp_q.delete();
        @(negedge clk);
        start = 1'b1; baseaddr = base[14:0]; len = l[9:0]; rows = r[9:0]; stride = st[14:0];
        qvalid = 1'b0; wgnt = 1'b0;
        @(negedge clk);
        start = 1'b0;
        #1;
        if (total == 0) begin
            chk("empty_done", done, 1'b1);
            chk("empty_wreq", wreq, 1'b0);
            @(negedge clk); #1;
            chk("empty_done_clr", done, 1'b0);
            chk("empty_idle", busy, 1'b0);
            return;
        end
        chk("start_busy", busy, 1'b1);
        while (!fin && cyc < 500) begin
            if (kill_mode != 0 && wr == kill_after) begin
                if (kill_mode == 1) begin
                    abort = 1'b1; qvalid = 1'b1; wgnt = 1'b1;
                    @(negedge clk);
                    abort = 1'b0; qvalid = 1'b0; wgnt = 1'b0;
                    #1;
                end else begin
                    clr_n = 1'b0;
                    #1;
                end
                chk("kill_wreq", wreq, 1'b0);
                chk("kill_busy", busy, 1'b0);
                chk("kill_done", done, 1'b0);
                @(negedge clk);
                clr_n = 1'b1; qvalid = 1'b0; wgnt = 1'b0;
                repeat (3) begin
                    @(negedge clk); #1;
                    chk("post_kill_quiet", {wreq, done, busy}, 3'b000);
                end
                return;
            end
            qvalid = ($urandom_range(99) < vprob);
            qdata  = {$urandom, $urandom};
            case (gmode)
                0: wgnt = 1'b1;
                1: wgnt = cyc[0];
                default: wgnt = $urandom_range(1);
            endcase
            start = mid_start && (cyc == 2);
            if (start) begin baseaddr = 15'h0; len = 10'd1; rows = 10'd1; end
            #1;
            if (prev_stall) chk("hold", {wreq, waddr, wdata}, {1'b1, prev_a, prev_d});
            if (wreq && !wgnt) chk("stall_qready", qready, 1'b0);
            chk("no_early_done", done, 1'b0);
            if (qvalid && qready) begin
                exp_q.push_back({addr_of(base, l, st, acc), qdata});
                if (acc == 0) first_acc = cyc;
                acc++;
            end
            if (acc > total) chk("over_accept", acc, total);
            if (wreq && wgnt) begin
                if (exp_q.size() == 0) begin
                    chk("spurious_write", wreq, 1'b0);
                end else begin
                    head = exp_q.pop_front();
                    chk("waddr", waddr, head[78:64]);
                    chk("wdata", wdata, head[63:0]);
                end
                if (wr == 0) first_gnt = cyc;
                last_gnt = cyc;
                wr++;
            end
            prev_stall = wreq && !wgnt;
            prev_a = waddr; prev_d = wdata;
            if (wr == total) fin = 1;
            @(negedge clk);
            start = 1'b0;
            cyc++;
        end
        if (!fin) begin
            chk("job_timeout", wr, total);
            return;
        end
        qvalid = 1'b0; wgnt = 1'b0;
        #1;
        chk("done_after_last", {done, busy}, 2'b11);
        if (full_rate) begin
            chk("first_wreq_latency", first_gnt - first_acc, 1);
            chk("full_rate_span", last_gnt - first_gnt, total - 1);
        end
        @(negedge clk); #1;
        chk("idle_after_done", {done, busy}, 2'b00);
    endtask

    initial begin
        clr_n = 1'b0; start = 1'b0; abort = 1'b0; qvalid = 1'b0; wgnt = 1'b0;
        baseaddr = '0; len = '0; rows = '0; stride = '0; qdata = '0;
        #2;
        chk("reset_ctrl", {qready, wreq, busy, done}, 4'b0000);
        chk("reset_waddr", waddr, 15'h0);
        chk("reset_wdata", wdata, 64'h0);
        @(negedge clk);
        @(negedge clk);
        clr_n = 1'b1;

        run_job(100, 4, 2, 16, 100, 0, 0, 0, 0, 1);
        run_job(100, 4, 2, 16, 100, 1, 0, 0, 0, 0);
        run_job(15'h7FFE, 4, 1, 0, 100, 0, 0, 0, 0, 1);
        run_job(50, 0, 3, 1, 100, 0, 0, 0, 0, 0);
        run_job(50, 3, 0, 1, 100, 0, 0, 0, 0, 0);
        run_job(200, 5, 3, 7, 100, 0, 0, 0, 1, 1);
        run_job(300, 8, 1, 0, 100, 0, 1, 3, 0, 0);
        run_job(40, 3, 2, 100, 100, 0, 0, 0, 0, 1);
        run_job(500, 8, 2, 20, 100, 0, 2, 2, 0, 0);
        run_job(77, 2, 3, 9, 100, 0, 0, 0, 0, 1);

        // start and abort together in IDLE: abort wins.
        @(negedge clk);
        start = 1'b1; abort = 1'b1; len = 10'd2; rows = 10'd2;
        @(negedge clk);
        start = 1'b0; abort = 1'b0;
        #1;
        chk("start_abort_idle", {busy, done}, 2'b00);

        for (int j = 0; j < 8; j++) begin
            run_job($urandom_range(32767), $urandom_range(6, 1), $urandom_range(4, 1),
                    $urandom_range(32767), $urandom_range(100, 40), 2, 0, 0, 0, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
